pwm_rate_sequencer: RTL and testbench
=====================================

Name: pwm_rate_sequencer

Overview:
- Controller that drives the `Rate` input and the reset of the existing PWM clock divider.
- Steps the divider through a 4-entry channel table (blue, yellow, green, red), each with its own rate and dwell.
- Dwell is measured in divider output toggles.
- Rate changes are made only immediately after a divider toggle, so every output half-period is generated with exactly one rate value.

Parameters:
- RATE_W, 24, width of rate values and of `rate_out`.
- DWELL_W, 16, width of dwell counts.
- RATE0..RATE3, 1388/1249/1332/1388, reset contents of the rate table (blue, yellow, green, red).
- DWELL0..DWELL3, 4, reset contents of the dwell table.

Ports:
- clk  in  1  system clock; same clock as the divider.
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is high.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  2  table index.
- cfg_rate  in  RATE_W  rate value to write.
- cfg_dwell  in  DWELL_W  dwell value to write; 0 disables the channel.
- loop  in  1  1 = repeat the sequence; 0 = one pass. Sampled at start.
- start  in  1  start pulse.
- stop  in  1  stop pulse.
- pwm_in  in  1  divider output (`CLK_PWM`), fed back.
- rate_out  out  RATE_W  to divider `Rate`.
- div_reset  out  1  to divider `reset`; held high while idle.
- chan  out  2  current channel index.
- busy  out  1  high in ARM, RUN and STOP.
- done  out  1  one-cycle pulse when the sequence ends.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
Reset values:
- Table returns to the parameter defaults.
- `rate_out`=0, `div_reset`=1, `chan`=0, `busy`=0, `done`=0, `err`=0.
- State = IDLE, dwell counter = 0, `pwm_q` = 0.

Table writes:
- A write with `cfg_we`=1 updates entry `cfg_addr` on the next edge, in any state.
- A `cfg_rate` value below 2 is stored as 2.
- A write to the active channel takes effect only when that channel is next loaded; the currently driven `rate_out` is not changed.

Toggle detect:
- `pwm_q` <= `pwm_in`; `tog` = `pwm_in` ^ `pwm_q`.
- `tog` is only evaluated in RUN and STOP; `pwm_q` tracks `pwm_in` in all states.

States:
- IDLE:
  - `div_reset`=1.
  - On `start` with no `stop`:
    - If no channel has nonzero dwell: pulse `err`, stay in IDLE.
    - Otherwise: `chan` <= lowest enabled index, `rate_out` <= its rate, dwell counter <= 0, latch `loop`, go to ARM.
  - `start` in any other state is ignored.
- ARM:
  - `div_reset` <= 0; go to RUN next cycle. The divider starts counting from 0 with the new rate already stable.
- RUN, on `tog`:
  - If counter == dwell[chan]-1: counter <= 0 and advance.
  - Otherwise: counter++.
- Advance:
  - Next channel is the next enabled index in ascending order.
  - If the search wraps past 3 and latched `loop`=0: pulse `done` and go to IDLE (`div_reset`=1 on the following cycle).
  - Otherwise: `chan` and `rate_out` load from the table. The update lands 1 cycle after the toggle, when the divider count is 1. This is safe because every rate is ≥ 2.
  - A single enabled channel with `loop`=1 reloads itself, so table edits are picked up.
  - Dwell values are read live. If the current channel's dwell is written to 0 mid-dwell, advance on the next `tog`.
- STOP:
  - Entered from ARM or RUN when `stop`=1; `stop` has priority over `start` and over an advance in the same cycle.
  - On the next `tog` (or immediately if coming from ARM): go to IDLE, with `done` pulsed.
  - `rate_out` is held.
- Reset in any state returns to the reset values on that edge; there is no partial completion and no `done` pulse.

Test Plan:
- Defaults: reset, then `start` with `loop`=0.
  - `rate_out` is 1388, 1249, 1332, 1388 in turn; each channel lasts 4 toggles.
  - Then `done` pulses once and `div_reset` returns to 1.
- Small table, `loop`=1: rates 2/3/4/5, dwell 2 each, divider model attached.
  - Half-periods are 3,3,4,4,5,5,6,6 cycles, then repeat.
  - `rate_out` changes exactly 1 cycle after each 2nd toggle.
- Disabled channels: dwell1=0, dwell3=0, `loop`=1.
  - Sequence is `chan` 0→2→0→2.
  - All dwells 0 plus `start` → `err` pulse; `busy` stays 0.
- Mid-run events:
  - Write rate 7 to the active channel: no change to `rate_out` until that channel is reloaded.
  - Write `cfg_rate`=1: it reads back as 2 at the next reload.
- `stop` and `start` in the same cycle during RUN: the sequencer stays in STOP until the next toggle, then goes to IDLE with one `done` pulse.
  - `stop` in ARM goes to IDLE the next cycle.
- `reset` asserted mid-dwell: on the next edge, `busy`=0, `div_reset`=1, `rate_out`=0, and the table is back to its defaults.

Source files
------------

// File: rtl/pwm_rate_sequencer.sv
// pwm_rate_sequencer
//
// Drives the Rate input and the reset of an external PWM clock divider. It
// steps the divider through a 4-entry channel table (blue, yellow, green, red).
// Each entry holds a rate and a dwell. The dwell is counted in divider output
// toggles. A new rate is applied only on the cycle right after a divider
// toggle, so each output half-period is generated with a single rate value.
//
// Handshake / control semantics: cfg_we is a level strobe that writes entry
// cfg_addr on the next edge in any state. start and stop are single-cycle
// pulses sampled on each edge. stop wins over start and over an advance in
// the same cycle. done and err are one-cycle pulses.
//
// Ports:
//   clk        system clock, shared with the divider
//   reset      synchronous active-high reset
//   cfg_we     table write strobe
//   cfg_addr   table index to write
//   cfg_rate   rate value to write (values below 2 are stored as 2)
//   cfg_dwell  dwell value to write (0 disables the channel)
//   loop       1 = repeat the sequence, 0 = single pass (latched at start)
//   start      start pulse (honoured only in IDLE)
//   stop       stop pulse (honoured in ARM and RUN)
//   pwm_in     divider output fed back for toggle detection
//   rate_out   rate presented to the divider
//   div_reset  divider reset, held high while idle
//   chan       current channel index
//   busy       high in ARM, RUN and STOP
//   done       one-cycle pulse when the sequence ends
//   err        one-cycle pulse when a start is rejected (no enabled channel)
//   dbg_state  current FSM state, for observation only

module pwm_rate_sequencer #(
    parameter int                  RATE_W  = 24,
    parameter int                  DWELL_W = 16,
    parameter logic [RATE_W-1:0]   RATE0   = RATE_W'(1388),
    parameter logic [RATE_W-1:0]   RATE1   = RATE_W'(1249),
    parameter logic [RATE_W-1:0]   RATE2   = RATE_W'(1332),
    parameter logic [RATE_W-1:0]   RATE3   = RATE_W'(1388),
    parameter logic [DWELL_W-1:0]  DWELL0  = DWELL_W'(4),
    parameter logic [DWELL_W-1:0]  DWELL1  = DWELL_W'(4),
    parameter logic [DWELL_W-1:0]  DWELL2  = DWELL_W'(4),
    parameter logic [DWELL_W-1:0]  DWELL3  = DWELL_W'(4)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [RATE_W-1:0]  cfg_rate,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    input  logic               pwm_in,
    output logic [RATE_W-1:0]  rate_out,
    output logic               div_reset,
    output logic [1:0]         chan,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         dbg_state
);

    localparam int CW = DWELL_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [RATE_W-1:0]   r_rate  [4];
    logic [DWELL_W-1:0]  r_dwell [4];
    logic [RATE_W-1:0]   r_rate_out;
    logic                r_div_reset;
    logic [1:0]          r_chan;
    logic                r_done;
    logic                r_err;
    logic [DWELL_W-1:0]  r_cnt;
    logic                r_loop;
    logic                r_stop_now;   // STOP entered from ARM: leave without waiting for a toggle
    logic                r_pwm_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t              w_state_nx;
    logic [RATE_W-1:0]   w_rate_out_nx;
    logic                w_div_reset_nx;
    logic [1:0]          w_chan_nx;
    logic                w_done_nx;
    logic                w_err_nx;
    logic [DWELL_W-1:0]  w_cnt_nx;
    logic                w_loop_nx;
    logic                w_stop_now_nx;

    logic                w_tog;
    logic [3:0]          w_en;
    logic                w_any_en;
    logic [1:0]          w_first;
    logic                w_up_found;
    logic [1:0]          w_up;
    logic [CW-1:0]       w_cnt_p1;
    logic                w_dwell_end;
    logic                w_load;
    logic [1:0]          w_load_idx;
    logic [RATE_W-1:0]   w_cfg_rate_clamped;

    assign w_tog = pwm_in ^ r_pwm_q;

    // Rates below 2 would let the divider toggle on the very count at which
    // a reload lands, so they are lifted to 2 on write.
    assign w_cfg_rate_clamped = (cfg_rate < RATE_W'(2)) ? RATE_W'(2) : cfg_rate;

    // ------------------------------------------------------------------
    // Channel table
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rate[0]  <= RATE0;
            r_rate[1]  <= RATE1;
            r_rate[2]  <= RATE2;
            r_rate[3]  <= RATE3;
            r_dwell[0] <= DWELL0;
            r_dwell[1] <= DWELL1;
            r_dwell[2] <= DWELL2;
            r_dwell[3] <= DWELL3;
        end else if (cfg_we) begin
            r_rate[cfg_addr]  <= w_cfg_rate_clamped;
            r_dwell[cfg_addr] <= cfg_dwell;
        end
    end

    // ------------------------------------------------------------------
    // Enabled-channel search
    //   w_first : lowest enabled index overall
    //   w_up    : lowest enabled index strictly above the current channel
    // Both loops scan downwards so the last hit is the lowest index.
    // ------------------------------------------------------------------
    always_comb begin
        w_en       = 4'b0000;
        w_any_en   = 1'b0;
        w_first    = 2'd0;
        w_up_found = 1'b0;
        w_up       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_en[i] = (r_dwell[i] != '0);
        end
        for (int i = 3; i >= 0; i--) begin
            if (w_en[i]) begin
                w_any_en = 1'b1;
                w_first  = 2'(i);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (w_en[i] && (i > int'(r_chan))) begin
                w_up_found = 1'b1;
                w_up       = 2'(i);
            end
        end
    end

    // Dwell is read live. Using >= rather than == means a dwell rewritten
    // to 0 (or below the current count) ends the dwell on the next toggle.
    assign w_cnt_p1    = {1'b0, r_cnt} + CW'(1);
    assign w_dwell_end = (w_cnt_p1 >= {1'b0, r_dwell[r_chan]});

    // ------------------------------------------------------------------
    // FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx     = r_state;
        w_rate_out_nx  = r_rate_out;
        w_div_reset_nx = r_div_reset;
        w_chan_nx      = r_chan;
        w_cnt_nx       = r_cnt;
        w_loop_nx      = r_loop;
        w_stop_now_nx  = r_stop_now;
        w_done_nx      = 1'b0;
        w_err_nx       = 1'b0;
        w_load         = 1'b0;
        w_load_idx     = 2'd0;

        case (r_state)
            S_IDLE: begin
                w_div_reset_nx = 1'b1;
                if (start && !stop) begin
                    if (!w_any_en) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = w_first;
                        w_cnt_nx   = '0;
                        w_loop_nx  = loop;
                        w_state_nx = S_ARM;
                    end
                end
            end

            S_ARM: begin
                if (stop) begin
                    // Divider never started; keep it in reset.
                    w_state_nx    = S_STOP;
                    w_stop_now_nx = 1'b1;
                end else begin
                    // Rate is already stable; release the divider.
                    w_div_reset_nx = 1'b0;
                    w_state_nx     = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    w_state_nx    = S_STOP;
                    w_stop_now_nx = 1'b0;
                end else if (w_tog) begin
                    if (w_dwell_end) begin
                        w_cnt_nx = '0;
                        if (w_up_found) begin
                            w_load     = 1'b1;
                            w_load_idx = w_up;
                        end else if (r_loop && w_any_en) begin
                            // Wrap; a lone enabled channel reloads itself.
                            w_load     = 1'b1;
                            w_load_idx = w_first;
                        end else begin
                            w_done_nx      = 1'b1;
                            w_div_reset_nx = 1'b1;
                            w_state_nx     = S_IDLE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + DWELL_W'(1);
                    end
                end
            end

            S_STOP: begin
                // Finish the half-period in flight before returning to idle.
                if (r_stop_now || w_tog) begin
                    w_done_nx      = 1'b1;
                    w_div_reset_nx = 1'b1;
                    w_stop_now_nx  = 1'b0;
                    w_state_nx     = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // The load lands one cycle after the toggle, when the divider count
        // is 1; any rate >= 2 cannot match there.
        if (w_load) begin
            w_chan_nx     = w_load_idx;
            w_rate_out_nx = r_rate[w_load_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rate_out  <= '0;
            r_div_reset <= 1'b1;
            r_chan      <= 2'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_loop      <= 1'b0;
            r_stop_now  <= 1'b0;
            r_pwm_q     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rate_out  <= w_rate_out_nx;
            r_div_reset <= w_div_reset_nx;
            r_chan      <= w_chan_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
            r_cnt       <= w_cnt_nx;
            r_loop      <= w_loop_nx;
            r_stop_now  <= w_stop_now_nx;
            r_pwm_q     <= pwm_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rate_out  = r_rate_out;
    assign div_reset = r_div_reset;
    assign chan      = r_chan;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pwm_rate_sequencer.sv
// Bench for pwm_rate_sequencer. A behavioural divider (half-period = rate+1
// cycles, count restarting from 0 on reset) is attached to the DUT. The
// reference model expands the channel table into the expected list of
// channel loads and half-period lengths.
module tb_pwm_rate_sequencer;

    localparam int RATE_W  = 24;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_addr = 2'd0;
    logic [RATE_W-1:0]  cfg_rate = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic               loop = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               pwm_in;
    logic [RATE_W-1:0]  rate_out;
    logic               div_reset;
    logic [1:0]         chan;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Bench copy of the table
    int m_rate  [4];
    int m_dwell [4];

    // Expected loads and half-periods
    logic [RATE_W-1:0] exp_rate_q [$];
    logic [1:0]        exp_chan_q [$];
    int                exp_hp_q   [$];

    always #5 clk = ~clk;

    pwm_rate_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_rate  (cfg_rate),
        .cfg_dwell (cfg_dwell),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .pwm_in    (pwm_in),
        .rate_out  (rate_out),
        .div_reset (div_reset),
        .chan      (chan),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Divider model
    logic [RATE_W-1:0] d_cnt = '0;
    logic              d_pwm = 1'b0;
    always @(posedge clk) begin
        if (div_reset !== 1'b0) begin
            d_cnt <= '0;
            d_pwm <= 1'b0;
        end else if (d_cnt == rate_out) begin
            d_cnt <= '0;
            d_pwm <= ~d_pwm;
        end else begin
            d_cnt <= d_cnt + RATE_W'(1);
        end
    end
    assign pwm_in = d_pwm;

    function automatic int clamp2(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_defaults();
        m_rate[0] = 1388; m_rate[1] = 1249; m_rate[2] = 1332; m_rate[3] = 1388;
        for (int i = 0; i < 4; i++) m_dwell[i] = 4;
    endtask

    task automatic cfg_write(input int addr, input int rate, input int dwell);
        cfg_addr  = 2'(addr);
        cfg_rate  = RATE_W'(rate);
        cfg_dwell = DWELL_W'(dwell);
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        m_rate[addr]  = clamp2(rate);
        m_dwell[addr] = dwell;
    endtask

    // Expand the table into loads and half-periods. A load triggered at
    // cumulative toggle count tg is suppressed when stop arrives with that
    // toggle (tg >= stop_k). A write issued at toggle wr_k is seen by loads
    // triggered at later toggles only.
    task automatic build_expect(input int passes, input int stop_k,
                                input int wr_k, input int wr_addr, input int wr_rate);
        int tg;
        int r;
        exp_rate_q.delete();
        exp_chan_q.delete();
        exp_hp_q.delete();
        tg = 0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_dwell[i] != 0 && (stop_k == 0 || tg < stop_k)) begin
                    r = (wr_k != 0 && i == wr_addr && tg > wr_k) ? clamp2(wr_rate) : m_rate[i];
                    exp_chan_q.push_back(2'(i));
                    exp_rate_q.push_back(RATE_W'(r));
                    for (int d = 0; d < m_dwell[i]; d++) begin
                        exp_hp_q.push_back(r + 1);
                        tg++;
                    end
                end
            end
        end
        if (stop_k != 0) begin
            while (exp_hp_q.size() > stop_k) void'(exp_hp_q.pop_back());
            exp_hp_q.push_back(exp_hp_q[stop_k-1]);
        end
    endtask

    task automatic run_check(input string name, input logic loop_v, input int stop_k,
                             input int wr_k, input int wr_addr, input int wr_rate,
                             input logic with_start, input int max_cyc);
        int cyc, last_edge, last_tog, ntog, hp, ehp;
        bit running, finished;
        logic prev_pwm;
        logic [RATE_W-1:0] prev_rate, er;
        logic [1:0] prev_chan, ec;
        loop  = loop_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        er = exp_rate_q.pop_front();
        ec = exp_chan_q.pop_front();
        n_vec++;
        if (busy !== 1'b1 || rate_out !== er || chan !== ec) begin
            n_err++;
            $display("FAIL %s first_load: busy=%0b rate_out=%0d chan=%0d, required busy=1 rate_out=%0d chan=%0d",
                     name, busy, rate_out, chan, er, ec);
        end
        prev_rate = rate_out; prev_chan = chan; prev_pwm = pwm_in;
        cyc = 0; last_edge = 0; last_tog = -10; ntog = 0; running = 0; finished = 0;
        while (!finished && cyc < max_cyc) begin
            tick();
            cyc++;
            stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
            if (!running && div_reset === 1'b0) begin
                running = 1; last_edge = cyc;
            end
            if (pwm_in !== prev_pwm) begin
                ntog++;
                hp  = cyc - last_edge;
                ehp = -1;
                if (exp_hp_q.size() > 0) ehp = exp_hp_q.pop_front();
                n_vec++;
                if (hp != ehp) begin
                    n_err++;
                    $display("FAIL %s half_period #%0d: got %0d cycles, required %0d", name, ntog, hp, ehp);
                end
                last_edge = cyc; last_tog = cyc; prev_pwm = pwm_in;
                if (ntog == stop_k) begin
                    stop = 1'b1; start = with_start;
                end
                if (ntog == wr_k) begin
                    cfg_addr  = 2'(wr_addr);
                    cfg_rate  = RATE_W'(wr_rate);
                    cfg_dwell = DWELL_W'(m_dwell[wr_addr]);
                    cfg_we    = 1'b1;
                end
            end
            if (rate_out !== prev_rate || chan !== prev_chan) begin
                n_vec++;
                if (exp_rate_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s load: unexpected rate_out=%0d chan=%0d at cycle %0d", name, rate_out, chan, cyc);
                end else begin
                    er = exp_rate_q.pop_front();
                    ec = exp_chan_q.pop_front();
                    if (rate_out !== er || chan !== ec || cyc != last_tog + 1) begin
                        n_err++;
                        $display("FAIL %s load: rate_out=%0d chan=%0d at +%0d after toggle, required rate_out=%0d chan=%0d at +1",
                                 name, rate_out, chan, cyc - last_tog, er, ec);
                    end
                end
                prev_rate = rate_out; prev_chan = chan;
            end
            if (done === 1'b1) begin
                finished = 1;
                n_vec++;
                if (cyc != last_tog + 1 || exp_hp_q.size() != 0 || exp_rate_q.size() != 0) begin
                    n_err++;
                    $display("FAIL %s done: at +%0d after toggle with %0d half-periods and %0d loads outstanding, required +1 with 0 and 0",
                             name, cyc - last_tog, exp_hp_q.size(), exp_rate_q.size());
                end
            end
        end
        stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
        if (!finished) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no done within %0d cycles", name, max_cyc);
        end
        if (wr_k != 0) m_rate[wr_addr] = clamp2(wr_rate);
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || div_reset !== 1'b1) begin
            n_err++;
            $display("FAIL %s after_done: done=%0b busy=%0b div_reset=%0b, required 0 0 1", name, done, busy, div_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_defaults();
        n_vec++;
        if (rate_out !== '0 || div_reset !== 1'b1 || chan !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs: rate_out=%0d div_reset=%0b chan=%0d, required 0 1 0", rate_out, div_reset, chan);
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%0b done=%0b err=%0b, required 0 0 0", busy, done, err);
        end
    endtask

    task automatic test_small_loop();
        for (int i = 0; i < 4; i++) cfg_write(i, 2 + i, 2);
        build_expect(3, 16, 0, 0, 0);
        // stop and start together on the toggle that would wrap the sequence
        run_check("small_loop_stop_start", 1'b1, 16, 0, 0, 0, 1'b1, 500);
    endtask

    task automatic test_mid_write_rate();
        build_expect(2, 12, 1, 0, 7);
        run_check("mid_write_rate7", 1'b1, 12, 1, 0, 7, 1'b0, 500);
    endtask

    task automatic test_mid_write_clamp();
        build_expect(2, 14, 5, 2, 1);
        run_check("mid_write_clamp", 1'b1, 14, 5, 2, 1, 1'b0, 500);
    endtask

    task automatic test_disabled();
        cfg_write(0, m_rate[0], 2);
        cfg_write(1, m_rate[1], 0);
        cfg_write(2, m_rate[2], 3);
        cfg_write(3, m_rate[3], 0);
        build_expect(3, 9, 0, 0, 0);
        run_check("disabled_chans", 1'b1, 9, 0, 0, 0, 1'b0, 500);
    endtask

    task automatic test_stop_in_arm();
        int done_cnt;
        int togs;
        logic p0;
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1;
        p0 = pwm_in;
        tick();
        stop = 1'b0;
        done_cnt = 0; togs = 0;
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1) done_cnt++;
            if (pwm_in !== p0) togs++;
            tick();
        end
        n_vec++;
        if (done_cnt != 1 || togs != 0) begin
            n_err++;
            $display("FAIL stop_in_arm: done pulses=%0d toggles=%0d, required 1 and 0", done_cnt, togs);
        end
        n_vec++;
        if (busy !== 1'b0 || div_reset !== 1'b1) begin
            n_err++;
            $display("FAIL stop_in_arm_idle: busy=%0b div_reset=%0b, required 0 1", busy, div_reset);
        end
    endtask

    task automatic check_err(input string name);
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse: err=%0b busy=%0b, required 1 0", name, err, busy);
        end
        tick();
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b0 || div_reset !== 1'b1) begin
            n_err++;
            $display("FAIL %s after: err=%0b busy=%0b div_reset=%0b, required 0 0 1", name, err, busy, div_reset);
        end
    endtask

    task automatic test_all_disabled_err();
        for (int i = 0; i < 4; i++) cfg_write(i, m_rate[i], 0);
        check_err("all_disabled_err");
    endtask

    task automatic test_random();
        bit any;
        for (int it = 0; it < 6; it++) begin
            any = 0;
            for (int i = 0; i < 4; i++) begin
                cfg_write(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
                if (m_dwell[i] != 0) any = 1;
            end
            if (any) begin
                build_expect(1, 0, 0, 0, 0);
                run_check($sformatf("random%0d", it), 1'b0, 0, 0, 0, 0, 1'b0, 400);
            end else begin
                check_err($sformatf("random%0d_err", it));
            end
        end
    endtask

    task automatic test_reset_mid_dwell();
        int togs;
        logic p;
        for (int i = 0; i < 4; i++) cfg_write(i, 3, 3);
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        togs = 0; p = pwm_in;
        for (int c = 0; c < 100 && togs < 2; c++) begin
            tick();
            if (pwm_in !== p) begin togs++; p = pwm_in; end
        end
        n_vec++;
        if (togs != 2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_setup: toggles=%0d busy=%0b, required 2 1", togs, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_defaults();
        n_vec++;
        if (busy !== 1'b0 || div_reset !== 1'b1 || rate_out !== '0 || chan !== 2'd0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%0b div_reset=%0b rate_out=%0d chan=%0d done=%0b, required 0 1 0 0 0",
                     busy, div_reset, rate_out, chan, done);
        end
    endtask

    // Runs on whatever the previous reset restored; no table writes here.
    task automatic test_defaults();
        build_expect(1, 0, 0, 0, 0);
        run_check("defaults", 1'b0, 0, 0, 0, 0, 1'b0, 25000);
    endtask

    initial begin
        test_reset();
        test_small_loop();
        test_mid_write_rate();
        test_mid_write_clamp();
        test_disabled();
        test_stop_in_arm();
        test_all_disabled_err();
        test_random();
        test_reset_mid_dwell();
        test_defaults();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
